fifo_write_ctrl: RTL and testbench

//  Write-side controller and status tracker for the single-clock RAM FIFO.

---
 rtl/fifo_write_ctrl_pkg.sv | 12 +
 rtl/fifo_write_ctrl_if.sv | 27 ++
 rtl/fifo_write_ctrl.sv | 85 ++++++++
 tb/tb_fifo_write_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_ctrl_pkg.sv
// Shared types for the single-clock RAM FIFO: RAM depth, address and occupancy widths.
package fifo_write_ctrl_pkg;

  localparam int maxramsize = 8;
  localparam int AddrW      = (maxramsize > 1) ? $clog2(maxramsize) : 1;
  localparam int CntW       = $clog2(maxramsize + 1);

  typedef logic              bit_t;
  typedef logic [AddrW-1:0]  RAM_size;
  typedef logic [CntW-1:0]   cnt_t;

endpackage

// File: rtl/fifo_write_ctrl_if.sv
// Request/status bundle between the FIFO write controller and its producer/consumer side.
interface fifo_write_ctrl_if;
  import fifo_write_ctrl_pkg::*;

  bit_t    clr;
  bit_t    push;
  bit_t    pop;
  RAM_size w_add;
  bit_t    w_en;
  bit_t    pop_ok;
  bit_t    full;
  bit_t    empty;
  cnt_t    count;
  bit_t    overflow;
  bit_t    underflow;

  modport master (
    output clr, push, pop,
    input  w_add, w_en, pop_ok, full, empty, count, overflow, underflow
  );

  modport slave (
    input  clr, push, pop,
    output w_add, w_en, pop_ok, full, empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_write_ctrl.sv
// Write-side controller of the RAM FIFO: qualifies push/pop against occupancy,
// drives the RAM write port and tracks count plus sticky overflow/underflow flags.
module fifo_write_ctrl
  import fifo_write_ctrl_pkg::*;
#(
  parameter int DEPTH = maxramsize
) (
  input  bit_t              clk,
  input  bit_t              reset,
  fifo_write_ctrl_if.slave  bus
);

  localparam RAM_size LastAddr = RAM_size'(DEPTH - 1);
  localparam cnt_t    FullCnt  = cnt_t'(DEPTH);

  RAM_size wptr_q, wptr_d;
  cnt_t    count_q, count_d;
  bit_t    overflow_q, overflow_d;
  bit_t    underflow_q, underflow_d;

  bit_t isFull;
  bit_t isEmpty;
  bit_t pushOk;
  bit_t popOk;

  // Status decodes only from the registered count; requests are gated off during clr and reset.
  always_comb begin
    isFull  = (count_q == FullCnt);
    isEmpty = (count_q == '0);
    popOk   = reset & ~bus.clr & bus.pop & ~isEmpty;
    pushOk  = reset & ~bus.clr & bus.push & (~isFull | popOk);
  end

  always_comb begin
    wptr_d      = wptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.clr) begin
      wptr_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (pushOk) begin
        wptr_d = (wptr_q == LastAddr) ? '0 : wptr_q + RAM_size'(1);
      end
      if (pushOk && !popOk) begin
        count_d = count_q + cnt_t'(1);
      end else if (popOk && !pushOk) begin
        count_d = count_q - cnt_t'(1);
      end
      if (bus.push && !pushOk) begin
        overflow_d = 1'b1;
      end
      if (bus.pop && isEmpty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.w_add     = wptr_q;
  assign bus.w_en      = pushOk;
  assign bus.pop_ok    = popOk;
  assign bus.full      = isFull;
  assign bus.empty     = isEmpty;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// Scoreboard bench for fifo_write_ctrl (DEPTH=8): expected per-cycle outputs are queued
// by the stimulus and checked by a negedge monitor, which also models the RAM and read pointer.
module tb_fifo_write_ctrl;
  import fifo_write_ctrl_pkg::*;

  typedef struct {
    logic    wEn;
    RAM_size wAdd;
    logic    popOk;
    cnt_t    count;
    logic    full;
    logic    empty;
    logic    ovf;
    logic    unf;
    string   name;
  } exp_t;

  bit_t clk;
  bit_t reset;
  fifo_write_ctrl_if bus ();

  fifo_write_ctrl #(.DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t       expQ[$];
  logic [7:0] refQ[$];
  logic [7:0] ram [0:7];
  logic [7:0] dataIn;
  logic [7:0] nextData;
  RAM_size    rptr;
  int         compared;
  int         mismatched;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(bit wEn, int wAdd, bit popOk, int count, bit ovf, bit unf, string name);
    exp_t e;
    e.wEn   = wEn;
    e.wAdd  = RAM_size'(wAdd);
    e.popOk = popOk;
    e.count = cnt_t'(count);
    e.full  = (count == 8);
    e.empty = (count == 0);
    e.ovf   = ovf;
    e.unf   = unf;
    e.name  = name;
    return e;
  endfunction

  task automatic applyStimulus(input bit p, input bit pp, input bit c, input exp_t e);
    @(posedge clk);
    #1;
    bus.push = p;
    bus.pop  = pp;
    bus.clr  = c;
    if (p) begin
      dataIn   = nextData;
      nextData = nextData + 8'd1;
    end
    if (e.wEn) refQ.push_back(dataIn);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    compared++;
    if (bus.w_en !== e.wEn || bus.w_add !== e.wAdd || bus.pop_ok !== e.popOk ||
        bus.count !== e.count || bus.full !== e.full || bus.empty !== e.empty ||
        bus.overflow !== e.ovf || bus.underflow !== e.unf) begin
      mismatched++;
      $display("[TB] FAIL %s: got w_en=%0b w_add=%0d pop_ok=%0b count=%0d full=%0b empty=%0b ovf=%0b unf=%0b, want w_en=%0b w_add=%0d pop_ok=%0b count=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
               e.name, bus.w_en, bus.w_add, bus.pop_ok, bus.count, bus.full, bus.empty,
               bus.overflow, bus.underflow, e.wEn, e.wAdd, e.popOk, e.count, e.full, e.empty,
               e.ovf, e.unf);
    end
  endtask

  // RAM read happens before the same-cycle write so a full push+pop reads the old entry.
  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
    if (!reset || bus.clr) begin
      rptr = '0;
      refQ.delete();
    end else begin
      if (bus.pop_ok) begin
        compared++;
        if (refQ.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL ramRead: pop_ok at rptr=%0d got %0h, want no pop (reference empty)", rptr, ram[rptr]);
        end else if (ram[rptr] !== refQ[0]) begin
          mismatched++;
          $display("[TB] FAIL ramRead: rptr=%0d got %0h, want %0h", rptr, ram[rptr], refQ[0]);
          void'(refQ.pop_front());
        end else begin
          void'(refQ.pop_front());
        end
        rptr = rptr + RAM_size'(1);
      end
      if (bus.w_en) ram[bus.w_add] = dataIn;
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    nextData   = 8'h10;
    dataIn     = 8'h00;
    rptr       = '0;
    reset      = 1'b0;
    bus.push   = 1'b0;
    bus.pop    = 1'b0;
    bus.clr    = 1'b0;
    for (int i = 0; i < 8; i++) ram[i] = 8'h00;

    applyStimulus(1, 1, 0, mk(0, 0, 0, 0, 0, 0, "resetPushGated"));
    applyStimulus(0, 0, 0, mk(0, 0, 0, 0, 0, 0, "resetIdle"));
    reset = 1'b1;
    applyStimulus(0, 0, 0, mk(0, 0, 0, 0, 0, 0, "idle"));

    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, mk(1, i, 0, i, 0, 0, "fillPush"));
    applyStimulus(1, 0, 0, mk(0, 0, 0, 8, 0, 0, "pushWhenFull"));
    applyStimulus(0, 0, 0, mk(0, 0, 0, 8, 1, 0, "overflowSticky"));

    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, mk(0, 0, 1, 8 - i, 1, 0, "drainPop"));
    applyStimulus(0, 1, 0, mk(0, 0, 0, 0, 1, 0, "popWhenEmpty"));
    applyStimulus(0, 0, 0, mk(0, 0, 0, 0, 1, 1, "underflowSticky"));
    applyStimulus(1, 0, 1, mk(0, 0, 0, 0, 1, 1, "clrFlags"));
    applyStimulus(0, 0, 0, mk(0, 0, 0, 0, 0, 0, "afterClrFlags"));

    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, mk(1, i, 0, i, 0, 0, "refill"));
    applyStimulus(1, 1, 0, mk(1, 0, 1, 8, 0, 0, "fullPushPop"));
    applyStimulus(0, 0, 0, mk(0, 1, 0, 8, 0, 0, "fullPushPopAfter"));
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, mk(0, 1, 1, 8 - i, 0, 0, "drain2"));
    applyStimulus(1, 1, 0, mk(1, 1, 0, 0, 0, 0, "emptyPushPop"));
    applyStimulus(0, 1, 0, mk(0, 2, 1, 1, 0, 1, "popAfterEmptyPP"));
    applyStimulus(0, 0, 1, mk(0, 2, 0, 0, 0, 1, "clrPtr"));
    applyStimulus(0, 0, 0, mk(0, 0, 0, 0, 0, 0, "afterClrPtr"));

    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 0, mk(1, i % 8, 0, 0, 0, 0, "wrapPush"));
      applyStimulus(0, 1, 0, mk(0, (i + 1) % 8, 1, 1, 0, 0, "wrapPop"));
    end

    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, mk(1, (4 + i) % 8, 0, i, 0, 0, "burstPush"));
    @(posedge clk);
    #1;
    bus.push = 1'b1;
    dataIn   = nextData;
    expQ.push_back(mk(0, 0, 0, 0, 0, 0, "resetAsync"));
    #2;
    reset = 1'b0;
    applyStimulus(1, 0, 0, mk(0, 0, 0, 0, 0, 0, "resetHold"));
    applyStimulus(0, 0, 0, mk(0, 0, 0, 0, 0, 0, "resetRelease"));
    reset = 1'b1;
    applyStimulus(0, 0, 0, mk(0, 0, 0, 0, 0, 0, "afterReset"));

    applyStimulus(0, 1, 0, mk(0, 0, 0, 0, 0, 0, "popEmpty2"));
    applyStimulus(1, 0, 0, mk(1, 0, 0, 0, 0, 1, "pushAfterUnf"));
    applyStimulus(1, 1, 1, mk(0, 1, 0, 1, 0, 1, "clrForce"));
    applyStimulus(0, 0, 0, mk(0, 0, 0, 0, 0, 0, "afterClrForce"));

    for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
    if (expQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
